// File: rtl/mouse_config_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mouse_config_sequencer_if
// Description : Byte-level link between the PS/2 mouse configuration
//               sequencer and the PS/2 transmitter/receiver pair.
//               master = sequencer side, slave = transceiver side.
//   SEND_BYTE       one-cycle transmit request (master -> slave)
//   BYTE_TO_SEND    byte to transmit, stable until BYTE_SENT (master -> slave)
//   BYTE_SENT       transmit completion pulse (slave -> master)
//   READ_ENABLE     receiver enable (master -> slave)
//   BYTE_READ       received byte (slave -> master)
//   BYTE_ERROR_CODE receiver error, nonzero = bad byte (slave -> master)
//   BYTE_READY      received byte valid pulse (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface mouse_config_sequencer_if;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;

    modport master (
        output SEND_BYTE,
        output BYTE_TO_SEND,
        output READ_ENABLE,
        input  BYTE_SENT,
        input  BYTE_READ,
        input  BYTE_ERROR_CODE,
        input  BYTE_READY
    );

    modport slave (
        input  SEND_BYTE,
        input  BYTE_TO_SEND,
        input  READ_ENABLE,
        output BYTE_SENT,
        output BYTE_READ,
        output BYTE_ERROR_CODE,
        output BYTE_READY
    );
endinterface
`default_nettype wire

// File: rtl/mouse_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mouse_config_sequencer
// Description : Walks a PS/2 mouse through reset, the IntelliMouse scroll
//               unlock knock (F3 C8 / F3 64 / F3 50), ID read, sample rate,
//               resolution and stream enable. Every command must be ACKed
//               (FA); any bad byte, receiver error or timeout restarts the
//               whole sequence until MAX_RETRY attempts have failed.
// Ports       :
//   CLK        system clock, rising edge
//   RESET      synchronous active-high reset
//   START      one-cycle pulse, honoured in IDLE/DONE/FAIL only
//   bus        transmitter/receiver link (master modport)
//   CFG_DONE   level, configuration succeeded
//   CFG_FAIL   level, retries exhausted
//   DEVICE_ID  ID byte returned after the F2 command
//   SCROLL_EN  high when DEVICE_ID == 8'h03 (registered)
//   STEP       current step index 0-12
//   RETRY_CNT  failed attempts so far
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_config_sequencer #(
    parameter int         TIMEOUT_CYCLES = 5000000,
    parameter int         MAX_RETRY      = 3,
    parameter logic [7:0] SAMPLE_RATE    = 8'd100,
    parameter logic [7:0] RESOLUTION     = 8'h02
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             START,
    mouse_config_sequencer_if.master         bus,
    output logic                             CFG_DONE,
    output logic                             CFG_FAIL,
    output logic [7:0]                       DEVICE_ID,
    output logic                             SCROLL_EN,
    output logic [3:0]                       STEP,
    output logic [1:0]                       RETRY_CNT
);

    localparam int c_TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] c_ACK     = 8'hFA;
    localparam logic [7:0] c_BAT_OK  = 8'hAA;
    localparam logic [7:0] c_PID     = 8'h00;
    localparam logic [7:0] c_WHEELID = 8'h03;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SEND      = 4'd1,
        WAIT_SENT = 4'd2,
        WAIT_ACK  = 4'd3,
        WAIT_BAT  = 4'd4,
        WAIT_PID  = 4'd5,
        WAIT_ID   = 4'd6,
        DONE      = 4'd7,
        FAIL      = 4'd8
    } state_t;

    // Command byte for each step of the configuration sequence.
    function automatic logic [7:0] f_stepByte(input logic [3:0] s);
        case (s)
            4'd0:    f_stepByte = 8'hFF;
            4'd1:    f_stepByte = 8'hF3;
            4'd2:    f_stepByte = 8'hC8;
            4'd3:    f_stepByte = 8'hF3;
            4'd4:    f_stepByte = 8'h64;
            4'd5:    f_stepByte = 8'hF3;
            4'd6:    f_stepByte = 8'h50;
            4'd7:    f_stepByte = 8'hF2;
            4'd8:    f_stepByte = 8'hF3;
            4'd9:    f_stepByte = SAMPLE_RATE;
            4'd10:   f_stepByte = 8'hE8;
            4'd11:   f_stepByte = RESOLUTION;
            4'd12:   f_stepByte = 8'hF4;
            default: f_stepByte = 8'h00;
        endcase
    endfunction

    state_t               r_state;
    logic [3:0]           r_step;
    logic [1:0]           r_retry;
    logic                 r_sendByte;
    logic [7:0]           r_byteToSend;
    logic                 r_readEnable;
    logic [7:0]           r_deviceId;
    logic                 r_scrollEn;
    logic                 r_cfgDone;
    logic                 r_cfgFail;
    logic [c_TIMER_W-1:0] r_timer;

    logic       w_inRecv;
    logic       w_expectOk;
    logic       w_rxGood;
    logic       w_rxBad;
    logic       w_timeout;
    logic       w_failure;
    logic [2:0] w_retryInc;
    logic       w_retryExhausted;
    logic       w_startOk;
    logic       w_enterSend;
    logic [3:0] w_sendStep;

    always_comb begin
        w_inRecv = (r_state == WAIT_ACK) || (r_state == WAIT_BAT) ||
                   (r_state == WAIT_PID) || (r_state == WAIT_ID);

        case (r_state)
            WAIT_ACK: w_expectOk = (bus.BYTE_READ == c_ACK);
            WAIT_BAT: w_expectOk = (bus.BYTE_READ == c_BAT_OK);
            WAIT_PID: w_expectOk = (bus.BYTE_READ == c_PID);
            WAIT_ID:  w_expectOk = 1'b1;
            default:  w_expectOk = 1'b0;
        endcase

        w_rxGood = w_inRecv && bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'b00) && w_expectOk;
        w_rxBad  = w_inRecv && bus.BYTE_READY && !((bus.BYTE_ERROR_CODE == 2'b00) && w_expectOk);

        // An arriving byte (or transmit completion) takes priority over a
        // timeout expiring on the same cycle.
        w_timeout = (r_timer == c_TIMEOUT_LAST) &&
                    (((r_state == WAIT_SENT) && !bus.BYTE_SENT) ||
                     (w_inRecv && !bus.BYTE_READY));

        w_failure        = w_rxBad || w_timeout;
        w_retryInc       = {1'b0, r_retry} + 3'd1;
        w_retryExhausted = (32'(w_retryInc) == MAX_RETRY);
        w_startOk        = START && ((r_state == IDLE) || (r_state == DONE) || (r_state == FAIL));

        // Every path that (re)issues a command funnels through here.
        w_enterSend = 1'b0;
        w_sendStep  = 4'd0;
        if (w_startOk) begin
            w_enterSend = 1'b1;
        end else if (w_failure && !w_retryExhausted) begin
            w_enterSend = 1'b1;
        end else if (w_rxGood) begin
            case (r_state)
                WAIT_ACK: begin
                    if ((r_step != 4'd0) && (r_step != 4'd7) && (r_step != 4'd12)) begin
                        w_enterSend = 1'b1;
                        w_sendStep  = r_step + 4'd1;
                    end
                end
                WAIT_PID: begin
                    w_enterSend = 1'b1;
                    w_sendStep  = 4'd1;
                end
                WAIT_ID: begin
                    w_enterSend = 1'b1;
                    w_sendStep  = 4'd8;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_step       <= 4'd0;
            r_retry      <= 2'd0;
            r_sendByte   <= 1'b0;
            r_byteToSend <= 8'h00;
            r_readEnable <= 1'b0;
            r_deviceId   <= 8'h00;
            r_scrollEn   <= 1'b0;
            r_cfgDone    <= 1'b0;
            r_cfgFail    <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_sendByte <= 1'b0;
            r_scrollEn <= (r_deviceId == c_WHEELID);

            if ((r_state == WAIT_SENT) || w_inRecv) begin
                r_timer <= r_timer + c_TIMER_W'(1);
            end

            case (r_state)
                SEND: begin
                    r_state <= WAIT_SENT;
                    r_timer <= '0;
                end
                WAIT_SENT: begin
                    if (bus.BYTE_SENT) begin
                        r_state      <= WAIT_ACK;
                        r_timer      <= '0;
                        r_readEnable <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (w_rxGood) begin
                        if (r_step == 4'd0) begin
                            r_state <= WAIT_BAT;
                            r_timer <= '0;
                        end else if (r_step == 4'd7) begin
                            r_state <= WAIT_ID;
                            r_timer <= '0;
                        end else if (r_step == 4'd12) begin
                            r_state      <= DONE;
                            r_readEnable <= 1'b0;
                            r_cfgDone    <= 1'b1;
                        end
                    end
                end
                WAIT_BAT: begin
                    if (w_rxGood) begin
                        r_state <= WAIT_PID;
                        r_timer <= '0;
                    end
                end
                WAIT_ID: begin
                    if (w_rxGood) begin
                        r_deviceId <= bus.BYTE_READ;
                    end
                end
                default: ;
            endcase

            if (w_startOk) begin
                r_retry    <= 2'd0;
                r_deviceId <= 8'h00;
                r_cfgDone  <= 1'b0;
                r_cfgFail  <= 1'b0;
            end

            if (w_failure) begin
                r_retry <= w_retryInc[1:0];
                if (w_retryExhausted) begin
                    r_state      <= FAIL;
                    r_readEnable <= 1'b0;
                    r_cfgFail    <= 1'b1;
                end
            end

            if (w_enterSend) begin
                r_state      <= SEND;
                r_step       <= w_sendStep;
                r_sendByte   <= 1'b1;
                r_byteToSend <= f_stepByte(w_sendStep);
                r_readEnable <= 1'b0;
            end
        end
    end

    assign bus.SEND_BYTE    = r_sendByte;
    assign bus.BYTE_TO_SEND = r_byteToSend;
    assign bus.READ_ENABLE  = r_readEnable;
    assign CFG_DONE         = r_cfgDone;
    assign CFG_FAIL         = r_cfgFail;
    assign DEVICE_ID        = r_deviceId;
    assign SCROLL_EN        = r_scrollEn;
    assign STEP             = r_step;
    assign RETRY_CNT        = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_mouse_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_config_sequencer
// Description : Scoreboard bench. A behavioural mouse answers each command
//               according to a per-attempt fault plan; a reference model
//               turns the same plan into the expected command stream and
//               final status, which a monitor pops as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_config_sequencer;

    localparam int         TO   = 100;
    localparam int         MAXR = 3;
    localparam logic [7:0] SR   = 8'd100;
    localparam logic [7:0] RES  = 8'h02;
    localparam logic [7:0] REF_TABLE [13] = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3,
                                               8'h50, 8'hF2, 8'hF3, SR, 8'hE8, RES, 8'hF4};

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic       CFG_DONE, CFG_FAIL, SCROLL_EN;
    logic [7:0] DEVICE_ID;
    logic [3:0] STEP;
    logic [1:0] RETRY_CNT;

    mouse_config_sequencer_if bus();

    mouse_config_sequencer #(
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRY      (MAXR),
        .SAMPLE_RATE    (SR),
        .RESOLUTION     (RES)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .bus       (bus),
        .CFG_DONE  (CFG_DONE),
        .CFG_FAIL  (CFG_FAIL),
        .DEVICE_ID (DEVICE_ID),
        .SCROLL_EN (SCROLL_EN),
        .STEP      (STEP),
        .RETRY_CNT (RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [3:0] step; logic [7:0] b; } send_t;
    typedef struct packed { logic done; logic fail; logic [1:0] retry; logic [7:0] id; logic scroll; } res_t;

    send_t expSend[$];
    res_t  expRes[$];

    // ---------------- stimulus plan ----------------
    // kind 0: FE reply, 1: FA with receiver error, 2: silent after send,
    // 3: transmitter never completes.
    int         planFaults;
    int         planIdx  [3];
    int         planKind [3];
    logic [7:0] planId;

    // Reference model: each failing attempt emits the table up to and
    // including the faulty step; the first clean attempt emits all 13.
    task automatic buildExpected();
        int         fails = 0;
        logic [7:0] latched = 8'h00;
        res_t       r;
        for (int a = 0; a < 8; a++) begin
            if (a < planFaults) begin
                for (int s = 0; s <= planIdx[a]; s++) expSend.push_back({4'(s), REF_TABLE[s]});
                if (planIdx[a] > 7) latched = planId;
                fails++;
                if (fails == MAXR) begin
                    r.done = 1'b0; r.fail = 1'b1; r.retry = 2'(fails);
                    r.id = latched; r.scroll = (latched == 8'h03);
                    expRes.push_back(r);
                    return;
                end
            end else begin
                for (int s = 0; s < 13; s++) expSend.push_back({4'(s), REF_TABLE[s]});
                r.done = 1'b1; r.fail = 1'b0; r.retry = 2'(fails);
                r.id = planId; r.scroll = (planId == 8'h03);
                expRes.push_back(r);
                return;
            end
        end
    endtask

    // ---------------- monitor ----------------
    send_t monE;
    res_t  monR;
    logic  prevDone = 1'b0;
    logic  prevFail = 1'b0;

    always @(negedge CLK) begin
        if (RESET) begin
            prevDone = 1'b0;
            prevFail = 1'b0;
        end else begin
            if (bus.SEND_BYTE) begin
                if (expSend.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("FAIL unexpected_send: got byte 0x%0h step %0d, expected no send", bus.BYTE_TO_SEND, STEP);
                end else begin
                    monE = expSend.pop_front();
                    check("send_byte", bus.BYTE_TO_SEND, monE.b);
                    check("send_step", STEP, monE.step);
                    check("send_read_enable_low", bus.READ_ENABLE, 0);
                end
            end
            if ((CFG_DONE && !prevDone) || (CFG_FAIL && !prevFail)) begin
                if (expRes.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("FAIL unexpected_result: got done=%0b fail=%0b, expected none", CFG_DONE, CFG_FAIL);
                end else begin
                    monR = expRes.pop_front();
                    check("res_done", CFG_DONE, monR.done);
                    check("res_fail", CFG_FAIL, monR.fail);
                    check("res_retry", RETRY_CNT, monR.retry);
                    check("res_device_id", DEVICE_ID, monR.id);
                    check("res_scroll", SCROLL_EN, monR.scroll);
                end
            end
            prevDone = CFG_DONE;
            prevFail = CFG_FAIL;
        end
    end

    // ---------------- behavioural mouse ----------------
    int         mAttempt;
    int         mIdx;
    logic [7:0] mByte;
    bit         hangReached;

    task automatic waitCyc(input int n);
        repeat (n) begin
            @(negedge CLK);
            bus.BYTE_SENT  = 1'b0;
            bus.BYTE_READY = 1'b0;
        end
    endtask

    task automatic rx(input logic [7:0] b, input logic [1:0] e);
        waitCyc(int'($urandom_range(1, 6)));
        check("rx_read_enable", bus.READ_ENABLE, 1);
        bus.BYTE_READ       = b;
        bus.BYTE_ERROR_CODE = e;
        bus.BYTE_READY      = 1'b1;
    endtask

    task automatic handleCmd();
        bit faulty;
        int kind;
        mByte = bus.BYTE_TO_SEND;
        if (mByte == 8'hFF) begin
            mAttempt++;
            mIdx = 0;
        end else begin
            mIdx++;
        end
        faulty = (mAttempt >= 0) && (mAttempt < planFaults) && (mIdx == planIdx[mAttempt]);
        kind   = faulty ? planKind[mAttempt] : -1;
        if (kind == 3) return;
        waitCyc(int'($urandom_range(1, 4)));
        check("byte_held_until_sent", bus.BYTE_TO_SEND, mByte);
        bus.BYTE_SENT = 1'b1;
        if (kind == 2) begin
            hangReached = 1'b1;
            return;
        end
        if (kind == 0) begin
            rx(8'hFE, 2'b00);
            return;
        end
        if (kind == 1) begin
            rx(8'hFA, 2'b01);
            return;
        end
        rx(8'hFA, 2'b00);
        if (mIdx == 0) begin
            rx(8'hAA, 2'b00);
            rx(8'h00, 2'b00);
        end else if (mIdx == 7) begin
            rx(planId, 2'b00);
        end
    endtask

    initial begin
        bus.BYTE_SENT       = 1'b0;
        bus.BYTE_READY      = 1'b0;
        bus.BYTE_READ       = 8'h00;
        bus.BYTE_ERROR_CODE = 2'b00;
        forever begin
            @(negedge CLK);
            bus.BYTE_SENT  = 1'b0;
            bus.BYTE_READY = 1'b0;
            if (bus.SEND_BYTE && !RESET) handleCmd();
        end
    end

    // ---------------- sequencing ----------------
    task automatic checkResetOutputs(input string tag);
        check({tag, "_send_byte"}, bus.SEND_BYTE, 0);
        check({tag, "_read_enable"}, bus.READ_ENABLE, 0);
        check({tag, "_byte_to_send"}, bus.BYTE_TO_SEND, 0);
        check({tag, "_step"}, STEP, 0);
        check({tag, "_retry"}, RETRY_CNT, 0);
        check({tag, "_device_id"}, DEVICE_ID, 0);
        check({tag, "_scroll"}, SCROLL_EN, 0);
        check({tag, "_cfg_done"}, CFG_DONE, 0);
        check({tag, "_cfg_fail"}, CFG_FAIL, 0);
    endtask

    task automatic pulseStart();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic setPlan(input logic [7:0] id, input int nF,
                           input int i0, input int k0, input int i1, input int k1,
                           input int i2, input int k2);
        planId = id; planFaults = nF;
        planIdx[0] = i0; planKind[0] = k0;
        planIdx[1] = i1; planKind[1] = k1;
        planIdx[2] = i2; planKind[2] = k2;
    endtask

    task automatic runScenario(input string name, input bit midStart);
        bit fin = 1'b0;
        int startAt = int'($urandom_range(5, 40));
        buildExpected();
        mAttempt = -1;
        mIdx     = 0;
        pulseStart();
        check({name, "_start_retry_clear"}, RETRY_CNT, 0);
        check({name, "_start_done_clear"}, CFG_DONE, 0);
        check({name, "_start_fail_clear"}, CFG_FAIL, 0);
        for (int c = 0; c < 5000 && !fin; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (CFG_DONE || CFG_FAIL) fin = 1'b1;
            else if (midStart && c == startAt) START = 1'b1;
        end
        START = 1'b0;
        check({name, "_finished_in_budget"}, fin, 1);
        repeat (3) @(negedge CLK);
        check({name, "_sends_drained"}, expSend.size(), 0);
        check({name, "_result_drained"}, expRes.size(), 0);
        if (!fin) begin
            RESET = 1'b1;
            @(negedge CLK);
            RESET = 1'b0;
            expSend.delete();
            expRes.delete();
        end
    endtask

    initial begin
        bit got;
        RESET = 1'b1;
        START = 1'b0;
        planFaults = 0;
        hangReached = 1'b0;
        repeat (3) @(negedge CLK);
        checkResetOutputs("por");
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        check("idle_no_send", bus.SEND_BYTE, 0);

        setPlan(8'h03, 0, 0, 0, 0, 0, 0, 0);  runScenario("wheel", 1'b0);
        setPlan(8'h00, 0, 0, 0, 0, 0, 0, 0);  runScenario("plain", 1'b0);
        setPlan(8'h03, 1, 4, 0, 0, 0, 0, 0);  runScenario("fe_step4", 1'b0);
        setPlan(8'h03, 3, 0, 2, 0, 2, 0, 2);  runScenario("silent", 1'b0);
        setPlan(8'h03, 0, 0, 0, 0, 0, 0, 0);  runScenario("restart_after_fail", 1'b0);
        setPlan(8'h03, 1, 2, 1, 0, 0, 0, 0);  runScenario("err_step2", 1'b0);
        setPlan(8'h03, 1, 9, 3, 0, 0, 0, 0);  runScenario("no_sent_step9", 1'b0);
        setPlan(8'h03, 3, 8, 0, 10, 1, 12, 2); runScenario("fail_with_id", 1'b0);

        // Reset while waiting for the ACK of step 5.
        setPlan(8'h03, 1, 5, 2, 0, 0, 0, 0);
        for (int s = 0; s <= 5; s++) expSend.push_back({4'(s), REF_TABLE[s]});
        hangReached = 1'b0;
        mAttempt = -1;
        mIdx = 0;
        pulseStart();
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge CLK);
            if (hangReached) got = 1'b1;
        end
        check("hang_reached", got, 1);
        repeat (3) @(negedge CLK);
        check("pre_reset_step", STEP, 5);
        check("pre_reset_read_enable", bus.READ_ENABLE, 1);
        RESET = 1'b1;
        @(negedge CLK);
        checkResetOutputs("mid_reset");
        RESET = 1'b0;
        check("mid_reset_sends_drained", expSend.size(), 0);
        repeat (250) @(negedge CLK);
        check("post_reset_step", STEP, 0);
        check("post_reset_done", CFG_DONE, 0);
        check("post_reset_fail", CFG_FAIL, 0);

        for (int n = 0; n < 8; n++) begin
            logic [7:0] id;
            id = ($urandom_range(0, 1) == 1) ? 8'h03 : 8'($urandom_range(0, 255));
            setPlan(id, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 3)));
            runScenario("random", 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
